// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared definitions for the fetch/issue front end.
//   - Base opcodes (instr[6:0]) of the nine instruction classes that are decoded.
//   - nextPc select encodings and trap-cause codes.
//   - Fetch/issue FSM state type and the one-hot class flag struct.
//   - next_pc(): resolves the next-PC select into a target address.
package riscv_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_L   = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_J   = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;

    localparam logic [1:0] NPC_SEQ  = 2'b00;
    localparam logic [1:0] NPC_JAL  = 2'b01;
    localparam logic [1:0] NPC_JALR = 2'b10;
    localparam logic [1:0] NPC_BR   = 2'b11;

    localparam logic [1:0] TC_NONE     = 2'b00;
    localparam logic [1:0] TC_ILLEGAL  = 2'b01;
    localparam logic [1:0] TC_MISALIGN = 2'b10;
    localparam logic [1:0] TC_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        TRAP  = 2'd3
    } state_t;

    // One bit per instruction class; at most one bit set.
    typedef struct packed {
        logic r;
        logic i;
        logic l;
        logic s;
        logic b;
        logic j;
        logic jr;
        logic lui;
        logic aui;
    } class_flags_t;

    // jalr targets always have bit 0 cleared; a branch not taken falls through.
    function automatic logic [31:0] next_pc(
        input logic [1:0]  sel,
        input logic        br_taken,
        input logic [31:0] pc_plus4,
        input logic [31:0] jal_target,
        input logic [31:0] jalr_target,
        input logic [31:0] br_target
    );
        logic [31:0] t;
        case (sel)
            NPC_SEQ:  t = pc_plus4;
            NPC_JAL:  t = jal_target;
            NPC_JALR: t = jalr_target & ~32'd1;
            default:  t = br_taken ? br_target : pc_plus4;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/opcode_class_decode.sv
// opcode_class_decode
//   Combinational classifier of a base opcode into one-hot class flags.
//   Ports:
//     opcode  in  7   instr[6:0]
//     flags   out 9   one-hot class flags (all 0 when illegal)
//     illegal out 1   instr[1:0] != 2'b11 or opcode not one of the nine classes
module opcode_class_decode
    import riscv_pkg::*;
(
    input  logic [6:0]   opcode,
    output class_flags_t flags,
    output logic         illegal
);

    always_comb begin
        flags   = '0;
        illegal = 1'b0;
        // Compressed encodings (low bits != 11) are not supported.
        if (opcode[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                OP_R:    flags.r   = 1'b1;
                OP_I:    flags.i   = 1'b1;
                OP_L:    flags.l   = 1'b1;
                OP_S:    flags.s   = 1'b1;
                OP_B:    flags.b   = 1'b1;
                OP_J:    flags.j   = 1'b1;
                OP_JR:   flags.jr  = 1'b1;
                OP_LUI:  flags.lui = 1'b1;
                OP_AUI:  flags.aui = 1'b1;
                default: illegal   = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/fetch_issue_unit.sv
// fetch_issue_unit
//   Holds the PC, fetches one instruction per turn over a req/ack handshake,
//   latches and classifies it, and applies the next-PC decision on retire.
//   Illegal instructions, misaligned targets and fetch timeouts trap; the trap
//   is sticky until rst.
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     imem_req/addr/ack/rdata   instruction memory handshake (req only in FETCH)
//     pc, pc_plus4, instr       held instruction and its PC
//     instr_valid               high while in ISSUE
//     R,I,L,S,B,J,Jr,lui,aui    one-hot class flags, gated by instr_valid
//     retire, nextPc, br_taken  downstream completion and next-PC select
//     jal/jalr/br_target        candidate targets
//     trap, trap_cause          sticky trap and its cause
module fetch_issue_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [7:0]  FETCH_TMO = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        R,
    output logic        I,
    output logic        L,
    output logic        S,
    output logic        B,
    output logic        J,
    output logic        Jr,
    output logic        lui,
    output logic        aui,
    input  logic        retire,
    input  logic [1:0]  nextPc,
    input  logic        br_taken,
    input  logic [31:0] jal_target,
    input  logic [31:0] jalr_target,
    input  logic [31:0] br_target,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    state_t       state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    class_flags_t flags_q, flags_d;
    class_flags_t dec_flags;
    logic         dec_illegal;
    logic [1:0]   cause_q, cause_d;
    logic [7:0]   tmo_q, tmo_d;
    logic [31:0]  seq_pc;
    logic [31:0]  target;

    // Classify the incoming word so the flags are registered with the instruction.
    opcode_class_decode u_dec (
        .opcode  (imem_rdata[6:0]),
        .flags   (dec_flags),
        .illegal (dec_illegal)
    );

    assign seq_pc = pc_q + 32'd4;
    assign target = next_pc(nextPc, br_taken, seq_pc, jal_target, jalr_target, br_target);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            flags_q <= '0;
            cause_q <= TC_NONE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            flags_q <= flags_d;
            cause_q <= cause_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        flags_d = flags_q;
        cause_d = cause_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                tmo_d   = '0;
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    if (dec_illegal) begin
                        flags_d = '0;
                        cause_d = TC_ILLEGAL;
                        state_d = TRAP;
                    end else begin
                        flags_d = dec_flags;
                        state_d = ISSUE;
                    end
                end else if (tmo_q + 8'd1 == FETCH_TMO) begin
                    // This is the FETCH_TMO-th cycle without an ack.
                    cause_d = TC_TIMEOUT;
                    state_d = TRAP;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ISSUE: begin
                if (retire) begin
                    if (target[1:0] != 2'b00) begin
                        // Keep the PC of the offending instruction for diagnosis.
                        cause_d = TC_MISALIGN;
                        state_d = TRAP;
                    end else begin
                        pc_d    = target;
                        tmo_d   = '0;
                        state_d = FETCH;
                    end
                end
            end
            TRAP: begin
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = seq_pc;
    assign instr       = instr_q;
    assign instr_valid = (state_q == ISSUE);
    assign trap        = (state_q == TRAP);
    assign trap_cause  = cause_q;

    assign R   = instr_valid & flags_q.r;
    assign I   = instr_valid & flags_q.i;
    assign L   = instr_valid & flags_q.l;
    assign S   = instr_valid & flags_q.s;
    assign B   = instr_valid & flags_q.b;
    assign J   = instr_valid & flags_q.j;
    assign Jr  = instr_valid & flags_q.jr;
    assign lui = instr_valid & flags_q.lui;
    assign aui = instr_valid & flags_q.aui;

endmodule

// File: tb/tb_fetch_issue_unit.sv
// tb_fetch_issue_unit
//   Transaction-level bench: each instruction is one fetch/issue/retire turn,
//   and the expected PC, class and trap outcome are computed from the
//   instruction-set rules directly.
module tb_fetch_issue_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [7:0]  TMO = 8'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] pc, pc_plus4, instr;
    logic        instr_valid;
    logic        R, I, L, S, B, J, Jr, lui, aui;
    logic        retire = 1'b0;
    logic [1:0]  nextPc = '0;
    logic        br_taken = 1'b0;
    logic [31:0] jal_target = '0, jalr_target = '0, br_target = '0;
    logic        trap;
    logic [1:0]  trap_cause;

    fetch_issue_unit #(.RESET_PC(RPC), .FETCH_TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pc(pc), .pc_plus4(pc_plus4), .instr(instr), .instr_valid(instr_valid),
        .R(R), .I(I), .L(L), .S(S), .B(B), .J(J), .Jr(Jr), .lui(lui), .aui(aui),
        .retire(retire), .nextPc(nextPc), .br_taken(br_taken),
        .jal_target(jal_target), .jalr_target(jalr_target), .br_target(br_target),
        .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    wire [8:0] fl = {R, I, L, S, B, J, Jr, lui, aui};

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mpc;
    bit          mtrap;
    logic [6:0]  ops [9];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected class flags {R,I,L,S,B,J,Jr,lui,aui}; zero means illegal.
    function automatic logic [8:0] cls(input logic [31:0] w);
        if (w[1:0] != 2'b11) return 9'd0;
        case (w[6:0])
            7'b0110011: return 9'b100000000;
            7'b0010011: return 9'b010000000;
            7'b0000011: return 9'b001000000;
            7'b0100011: return 9'b000100000;
            7'b1100011: return 9'b000010000;
            7'b1101111: return 9'b000001000;
            7'b1100111: return 9'b000000100;
            7'b0110111: return 9'b000000010;
            7'b0010111: return 9'b000000001;
            default:    return 9'd0;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; imem_ack = 1'b0; retire = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_pc", pc, RPC);
        chk("rst_instr", instr, 32'd0);
        chk("rst_vld", instr_valid, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_trap", trap, 0);
        chk("rst_cause", trap_cause, 0);
        chk("rst_flags", fl, 0);
        mpc   = RPC;
        mtrap = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (imem_req) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        ok = imem_req;
    endtask

    // One fetch/issue/retire turn. ad = cycles of ack delay, rd = cycles before retire.
    task automatic run_instr(input logic [31:0] w, input int ad, input int rd,
                             input logic [1:0] np, input bit tk,
                             input logic [31:0] jt, input logic [31:0] jrt, input logic [31:0] bt);
        bit          ok;
        logic [31:0] tgt;
        wait_req(ok);
        chk("req", imem_req, 1);
        if (!ok) begin
            mtrap = 1'b1;
            return;
        end
        chk("addr", imem_addr, mpc);
        for (int k = 0; k < ad; k++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            chk("ack_wait_notrap", trap, 0);
            chk("ack_wait_req", imem_req, 1);
        end
        imem_ack = 1'b1; imem_rdata = w;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = $urandom;
        if (cls(w) == 9'd0) begin
            chk("ill_trap", trap, 1);
            chk("ill_cause", trap_cause, 1);
            chk("ill_vld", instr_valid, 0);
            chk("ill_req", imem_req, 0);
            chk("ill_flags", fl, 0);
            mtrap = 1'b1;
            return;
        end
        chk("iss_vld", instr_valid, 1);
        chk("iss_instr", instr, w);
        chk("iss_flags", fl, cls(w));
        chk("iss_pc", pc, mpc);
        chk("iss_pc4", pc_plus4, mpc + 32'd4);
        chk("iss_req", imem_req, 0);
        for (int k = 0; k < rd; k++) begin
            // Stray acks while holding must be ignored.
            imem_ack = 1'($urandom); imem_rdata = $urandom;
            @(negedge clk);
            chk("hold_vld", instr_valid, 1);
            chk("hold_instr", instr, w);
        end
        imem_ack = 1'b0; retire = 1'b1; nextPc = np; br_taken = tk;
        jal_target = jt; jalr_target = jrt; br_target = bt;
        case (np)
            2'b00:   tgt = mpc + 32'd4;
            2'b01:   tgt = jt;
            2'b10:   tgt = {jrt[31:1], 1'b0};
            default: tgt = tk ? bt : mpc + 32'd4;
        endcase
        @(negedge clk);
        retire = 1'b0; nextPc = 2'($urandom); jal_target = $urandom;
        if (tgt[1:0] != 2'b00) begin
            chk("mis_trap", trap, 1);
            chk("mis_cause", trap_cause, 2);
            chk("mis_pc", pc, mpc);
            chk("mis_req", imem_req, 0);
            chk("mis_vld", instr_valid, 0);
            mtrap = 1'b1;
        end else begin
            mpc = tgt;
            chk("ret_vld", instr_valid, 0);
            chk("ret_req", imem_req, 1);
            chk("ret_addr", imem_addr, tgt);
            chk("ret_notrap", trap, 0);
        end
    endtask

    function automatic logic [31:0] rnd_tgt();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(0, 9) != 0) t[1:0] = 2'b00;
        return t;
    endfunction

    function automatic logic [31:0] rnd_jalr();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(0, 9) != 0) t[1] = 1'b0;
        return t;
    endfunction

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        int          r;
        w = $urandom;
        r = $urandom_range(0, 19);
        if (r == 0)      w[1:0] = 2'($urandom_range(0, 2));
        else if (r == 1) w[6:0] = 7'b1111111;
        else             w[6:0] = ops[$urandom_range(0, 8)];
        return w;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

        do_reset();

        // Sequential addi stream at 0,4,8,c.
        for (int k = 0; k < 4; k++) run_instr(32'h0000_0013, 0, 0, 2'b00, 0, 0, 0, 0);
        // jal at 0x10 to 0x18, then back-to-back branch tests at 0x20.
        run_instr(32'h0080_006F, 0, 0, 2'b01, 0, 32'h18, 0, 0);
        run_instr(32'h0080_006F, 1, 0, 2'b01, 0, 32'h20, 0, 0);
        run_instr(32'h0000_0063, 0, 1, 2'b11, 0, 0, 0, 32'h40);
        run_instr(32'h0080_006F, 0, 0, 2'b01, 0, 32'h20, 0, 0);
        run_instr(32'h0000_0063, 0, 0, 2'b11, 1, 0, 0, 32'h40);
        // jalr: bit 0 is dropped, bit 1 traps.
        run_instr(32'h0000_0067, 0, 0, 2'b10, 0, 0, 32'h101, 0);
        run_instr(32'h0000_0067, 0, 0, 2'b10, 0, 0, 32'h102, 0);
        @(negedge clk);
        chk("mis_sticky", trap, 1);
        chk("mis_sticky_req", imem_req, 0);
        do_reset();

        // Illegal word.
        run_instr(32'hFFFF_FFFF, 0, 0, 2'b00, 0, 0, 0, 0);
        do_reset();

        // Fetch timeout: trap after TMO fetch cycles without ack; later acks ignored.
        wait_req(ok);
        chk("tmo_req", imem_req, 1);
        for (int k = 0; k < int'(TMO) - 1; k++) begin
            @(negedge clk);
            chk("tmo_early", trap, 0);
        end
        @(negedge clk);
        chk("tmo_trap", trap, 1);
        chk("tmo_cause", trap_cause, 3);
        chk("tmo_req_off", imem_req, 0);
        imem_ack = 1'b1; imem_rdata = 32'h13;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("tmo_sticky", trap, 1);
        chk("tmo_vld", instr_valid, 0);
        do_reset();

        // PC wraps from 0xFFFFFFFC to 0 without trapping.
        run_instr(32'h0000_0013, 0, 0, 2'b01, 0, 32'hFFFF_FFFC, 0, 0);
        run_instr(32'h0000_0033, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("wrap_pc", mpc, 32'd0);

        // Reset in ISSUE together with retire.
        run_instr(32'h0000_0013, 0, 0, 2'b01, 0, 32'h200, 0, 0);
        wait_req(ok);
        imem_ack = 1'b1; imem_rdata = 32'h0000_0017;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("ri_vld", instr_valid, 1);
        rst = 1'b1; retire = 1'b1; nextPc = 2'b01; jal_target = 32'h80;
        @(negedge clk);
        rst = 1'b0; retire = 1'b0;
        chk("ri_pc", pc, RPC);
        chk("ri_flags", fl, 0);
        chk("ri_vld0", instr_valid, 0);
        chk("ri_req_idle", imem_req, 0);
        @(negedge clk);
        chk("ri_req_fetch", imem_req, 1);
        chk("ri_addr", imem_addr, RPC);

        // Reset in FETCH with a same-cycle ack drops the ack.
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0000_0033;
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b0;
        chk("rf_instr", instr, 0);
        chk("rf_req", imem_req, 0);
        mpc = RPC; mtrap = 1'b0;

        // Randomised turns.
        for (int n = 0; n < 300; n++) begin
            if (mtrap) do_reset();
            run_instr(rnd_word(), $urandom_range(0, int'(TMO) - 1), $urandom_range(0, 2),
                      2'($urandom), 1'($urandom), rnd_tgt(), rnd_jalr(), rnd_tgt());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
